div_issue: RTL

//   EX-stage issue/retire controller for RV32M DIV/DIVU/REM/REMU. Accepts a divide request from the EX stage.

---
 rtl/div_issue_pkg.sv | 19 +
 rtl/div_issue_if.sv | 47 ++++
 rtl/div_issue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_issue_pkg.sv
// Shared types and funct3 encodings for the RV32M divide issue controller.
// Imported by the interface, the controller and its bench.
package div_issue_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } div_issue_state_t;

endpackage

// File: rtl/div_issue_if.sv
// EX-stage request, writeback and divider bundle for div_issue.
// slave is the controller side; master is the EX/divider side.
interface div_issue_if #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
);

  logic             req_valid_i;
  logic [2:0]       req_op_i;
  logic [WIDTH-1:0] req_dividend_i;
  logic [WIDTH-1:0] req_divisor_i;
  logic [RD_W-1:0]  req_rd_i;
  logic             flush_i;
  logic             stall_o;
  logic             wb_valid_o;
  logic [WIDTH-1:0] wb_data_o;
  logic [RD_W-1:0]  wb_rd_o;
  logic             div_valid_o;
  logic [2:0]       div_op_o;
  logic [WIDTH-1:0] div_dividend_o;
  logic [WIDTH-1:0] div_divisor_o;
  logic [WIDTH-1:0] div_result_i;
  logic             div_ready_i;

  modport slave (
    input  req_valid_i, req_op_i,
    input  req_dividend_i, req_divisor_i,
    input  req_rd_i, flush_i,
    input  div_result_i, div_ready_i,
    output stall_o, wb_valid_o,
    output wb_data_o, wb_rd_o,
    output div_valid_o, div_op_o,
    output div_dividend_o, div_divisor_o
  );

  modport master (
    output req_valid_i, req_op_i,
    output req_dividend_i, req_divisor_i,
    output req_rd_i, flush_i,
    output div_result_i, div_ready_i,
    input  stall_o, wb_valid_o,
    input  wb_data_o, wb_rd_o,
    input  div_valid_o, div_op_o,
    input  div_dividend_o, div_divisor_o
  );

endinterface

// File: rtl/div_issue.sv
// Issue/retire controller for DIV/DIVU/REM/REMU with a one-entry
// result cache that retires exact repeats without the divider.
module div_issue
  import div_issue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input logic  clk_i,
  input logic  rst_ni,
  div_issue_if.slave bus
);

  div_issue_state_t state_q, state_d;

  logic             take;
  logic             hit;
  logic             fin;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [RD_W-1:0]  rd_q;

  logic             c_vld_q;
  logic [2:0]       c_op_q;
  logic [WIDTH-1:0] c_dvd_q;
  logic [WIDTH-1:0] c_dvs_q;
  logic [WIDTH-1:0] c_res_q;

  logic [WIDTH-1:0] wb_data_q;
  logic [RD_W-1:0]  wb_rd_q;

  assign take = bus.req_valid_i
              & bus.req_op_i[2]
              & ~bus.flush_i;

  assign hit = c_vld_q
             & (c_op_q  == bus.req_op_i)
             & (c_dvd_q == bus.req_dividend_i)
             & (c_dvs_q == bus.req_divisor_i);

  // flush beats a same-cycle ready: result dropped, cache untouched
  assign fin = (state_q == WAIT)
             & bus.div_ready_i
             & ~bus.flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take) state_d = hit ? DONE : WAIT;
      end
      WAIT: begin
        if (bus.flush_i)          state_d = IDLE;
        else if (bus.div_ready_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall_o     = 1'b0;
    bus.div_valid_o = 1'b0;
    bus.wb_valid_o  = 1'b0;
    unique case (state_q)
      IDLE: bus.stall_o = take;
      WAIT: begin
        bus.stall_o     = 1'b1;
        bus.div_valid_o = 1'b1;
      end
      DONE:    bus.wb_valid_o = ~bus.flush_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rd_q      <= '0;
      c_vld_q   <= 1'b0;
      c_op_q    <= '0;
      c_dvd_q   <= '0;
      c_dvs_q   <= '0;
      c_res_q   <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      if ((state_q == IDLE) && take) begin
        op_q  <= bus.req_op_i;
        dvd_q <= bus.req_dividend_i;
        dvs_q <= bus.req_divisor_i;
        rd_q  <= bus.req_rd_i;
        if (hit) begin
          wb_data_q <= c_res_q;
          wb_rd_q   <= bus.req_rd_i;
        end
      end
      if (fin) begin
        wb_data_q <= bus.div_result_i;
        wb_rd_q   <= rd_q;
        c_vld_q   <= 1'b1;
        c_op_q    <= op_q;
        c_dvd_q   <= dvd_q;
        c_dvs_q   <= dvs_q;
        c_res_q   <= bus.div_result_i;
      end
    end
  end

  assign bus.div_op_o       = op_q;
  assign bus.div_dividend_o = dvd_q;
  assign bus.div_divisor_o  = dvs_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.wb_rd_o        = wb_rd_q;

endmodule
